// File: rtl/forward_pkg.sv
// Shared definitions for the EX-stage forwarding unit: select codes, slot record
// layout and producer readiness constants.
package forward_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int SEL_W      = 4;
    localparam int NUM_SLOTS  = 8;

    localparam logic [3:0] SEL_DEFAULT = 4'd0;
    localparam logic [3:0] SEL_EX3     = 4'd1;
    localparam logic [3:0] SEL_EX4     = 4'd2;
    localparam logic [3:0] SEL_EX5     = 4'd3;
    localparam logic [3:0] SEL_EX6     = 4'd4;
    localparam logic [3:0] SEL_EX7     = 4'd5;
    localparam logic [3:0] SEL_SAD     = 4'd6;
    localparam logic [3:0] SEL_MEM     = 4'd7;
    localparam logic [3:0] SEL_WB      = 4'd8;

    localparam logic [3:0] READY_ALU  = 4'd1;
    localparam logic [3:0] READY_SAD  = 4'd6;
    localparam logic [3:0] READY_LOAD = 4'd7;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic [3:0]            ready;
    } slot_t;

    // Producers cannot be forwardable before slot 1 nor later than the last slot.
    function automatic logic [3:0] clamp_ready(input logic [3:0] stage);
        logic [3:0] r;
        if (stage == 4'd0) begin
            r = 4'd1;
        end else if (stage > 4'd8) begin
            r = 4'd8;
        end else begin
            r = stage;
        end
        return r;
    endfunction

endpackage

// File: rtl/forward_match.sv
// Priority encoder over the producer slots for a single source operand: finds the
// youngest matching producer and reports either its select code or a stall request.
module forward_match
    import forward_pkg::*;
#(
    parameter int REG_ADDR_W = forward_pkg::REG_ADDR_W,
    parameter int SEL_W      = forward_pkg::SEL_W,
    parameter int NUM_SLOTS  = forward_pkg::NUM_SLOTS
) (
    input  logic [REG_ADDR_W-1:0]           operand,
    input  logic [NUM_SLOTS-1:0]            slot_valid,
    input  logic [NUM_SLOTS*REG_ADDR_W-1:0] slot_dest,
    input  logic [NUM_SLOTS*4-1:0]          slot_ready,
    output logic [SEL_W-1:0]                sel,
    output logic                            stall_req
);

    logic [SEL_W-1:0] sel_s;
    logic             stall_s;
    logic             found_s;

    // Only the lowest-numbered (youngest) match decides; older copies are stale.
    always_comb begin
        sel_s   = SEL_W'(SEL_DEFAULT);
        stall_s = 1'b0;
        found_s = 1'b0;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            if (!found_s && (operand != '0) && slot_valid[k-1] &&
                (slot_dest[(k-1)*REG_ADDR_W +: REG_ADDR_W] == operand)) begin
                found_s = 1'b1;
                if (4'(k) >= slot_ready[(k-1)*4 +: 4]) begin
                    sel_s = SEL_W'(k);
                end else begin
                    stall_s = 1'b1;
                end
            end else begin
                found_s = found_s;
            end
        end
    end

    assign sel       = sel_s;
    assign stall_req = stall_s;

endmodule

// File: rtl/forward_select_unit.sv
// EX-stage forwarding select generator: tracks in-flight producers in a shifting
// scoreboard and drives operand-mux selects plus a load/multi-cycle-use stall.
module forward_select_unit
    import forward_pkg::*;
#(
    parameter int REG_ADDR_W = forward_pkg::REG_ADDR_W,
    parameter int SEL_W      = forward_pkg::SEL_W,
    parameter int NUM_SLOTS  = forward_pkg::NUM_SLOTS
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  EX_Valid,
    input  logic [REG_ADDR_W-1:0] EX_Rs,
    input  logic [REG_ADDR_W-1:0] EX_Rt,
    input  logic [REG_ADDR_W-1:0] EX_Rd,
    input  logic                  EX_RegWrite,
    input  logic [3:0]            EX_ResultStage,
    input  logic                  Flush,
    output logic [SEL_W-1:0]      ALU_input_rs,
    output logic [SEL_W-1:0]      ALU_input_rt,
    output logic                  Stall
);

    slot_t                           slots_r [1:NUM_SLOTS];
    logic [NUM_SLOTS-1:0]            slot_valid_s;
    logic [NUM_SLOTS*REG_ADDR_W-1:0] slot_dest_s;
    logic [NUM_SLOTS*4-1:0]          slot_ready_s;
    logic [SEL_W-1:0]                rs_sel_s;
    logic [SEL_W-1:0]                rt_sel_s;
    logic                            rs_stall_req_s;
    logic                            rt_stall_req_s;
    logic                            stall_s;
    logic                            load_valid_s;

    // Flatten the scoreboard for the per-operand encoders.
    always_comb begin
        slot_valid_s = '0;
        slot_dest_s  = '0;
        slot_ready_s = '0;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            slot_valid_s[k-1]                           = slots_r[k].valid;
            slot_dest_s[(k-1)*REG_ADDR_W +: REG_ADDR_W] = slots_r[k].dest;
            slot_ready_s[(k-1)*4 +: 4]                  = slots_r[k].ready;
        end
    end

    forward_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .SEL_W      (SEL_W),
        .NUM_SLOTS  (NUM_SLOTS)
    ) u_match_rs (
        .operand    (EX_Rs),
        .slot_valid (slot_valid_s),
        .slot_dest  (slot_dest_s),
        .slot_ready (slot_ready_s),
        .sel        (rs_sel_s),
        .stall_req  (rs_stall_req_s)
    );

    forward_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .SEL_W      (SEL_W),
        .NUM_SLOTS  (NUM_SLOTS)
    ) u_match_rt (
        .operand    (EX_Rt),
        .slot_valid (slot_valid_s),
        .slot_dest  (slot_dest_s),
        .slot_ready (slot_ready_s),
        .sel        (rt_sel_s),
        .stall_req  (rt_stall_req_s)
    );

    // Flush overrides any stall: the squashed instruction never waits on operands.
    always_comb begin
        stall_s      = EX_Valid & ~Flush & (rs_stall_req_s | rt_stall_req_s);
        load_valid_s = EX_Valid & EX_RegWrite & (EX_Rd != '0) & ~stall_s & ~Flush;
        if (EX_Valid) begin
            ALU_input_rs = rs_sel_s;
            ALU_input_rt = rt_sel_s;
        end else begin
            ALU_input_rs = SEL_W'(SEL_DEFAULT);
            ALU_input_rt = SEL_W'(SEL_DEFAULT);
        end
    end

    assign Stall = stall_s;

    // Scoreboard advances every cycle, even while stalled, so older producers mature.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 1; k <= NUM_SLOTS; k++) begin
                slots_r[k] <= '0;
            end
        end else begin
            slots_r[1] <= '{valid: load_valid_s,
                            dest:  EX_Rd,
                            ready: clamp_ready(EX_ResultStage)};
            for (int k = 2; k <= NUM_SLOTS; k++) begin
                slots_r[k] <= slots_r[k-1];
            end
        end
    end

endmodule

// File: tb/tb_forward_select_unit.sv
// Self-checking bench for forward_select_unit: scenario tasks push expected
// {rs sel, rt sel, stall} per driven cycle and compare against the DUT.
module tb_forward_select_unit;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b1;
    logic       EX_Valid = 1'b0;
    logic [4:0] EX_Rs = 5'd0;
    logic [4:0] EX_Rt = 5'd0;
    logic [4:0] EX_Rd = 5'd0;
    logic       EX_RegWrite = 1'b0;
    logic [3:0] EX_ResultStage = 4'd0;
    logic       Flush = 1'b0;
    logic [3:0] ALU_input_rs;
    logic [3:0] ALU_input_rt;
    logic       Stall;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q [$];

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic [3:0] st;
        logic       fl;
        logic [3:0] ers;
        logic [3:0] ert;
        logic       est;
    } step_t;

    forward_select_unit dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .EX_Valid       (EX_Valid),
        .EX_Rs          (EX_Rs),
        .EX_Rt          (EX_Rt),
        .EX_Rd          (EX_Rd),
        .EX_RegWrite    (EX_RegWrite),
        .EX_ResultStage (EX_ResultStage),
        .Flush          (Flush),
        .ALU_input_rs   (ALU_input_rs),
        .ALU_input_rt   (ALU_input_rt),
        .Stall          (Stall)
    );

    always #5 Clk = ~Clk;

    function automatic step_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic rw, input logic [3:0] st,
                                 input logic fl, input logic [3:0] ers, input logic [3:0] ert,
                                 input logic est);
        step_t s;
        s.v = v; s.rs = rs; s.rt = rt; s.rd = rd; s.rw = rw; s.st = st; s.fl = fl;
        s.ers = ers; s.ert = ert; s.est = est;
        return s;
    endfunction

    task automatic drive(input step_t s);
        @(posedge Clk);
        #1;
        EX_Valid = s.v; EX_Rs = s.rs; EX_Rt = s.rt; EX_Rd = s.rd;
        EX_RegWrite = s.rw; EX_ResultStage = s.st; Flush = s.fl;
        exp_q.push_back({s.ers, s.ert, s.est});
        @(negedge Clk);
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        EX_Valid = 1'b0; EX_Rs = 5'd0; EX_Rt = 5'd0; EX_Rd = 5'd0;
        EX_RegWrite = 1'b0; EX_ResultStage = 4'd0; Flush = 1'b0;
        @(negedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] exp_v;
        logic [8:0] got;
        #1;
        Rst_n = 1'b0;
        EX_Valid = 1'b1; EX_Rs = 5'd5; EX_Rt = 5'd6;
        exp_q.push_back({4'd0, 4'd0, 1'b0});
        #2;
        exp_v = exp_q.pop_front(); got = {ALU_input_rs, ALU_input_rt, Stall};
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL reset_hold: got rs=%b rt=%b stall=%b, want rs=%b rt=%b stall=%b",
                     got[8:5], got[4:1], got[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
        end
        @(negedge Clk);
        #1;
        Rst_n = 1'b1;
        drive(mk(1'b1, 5'd5, 5'd6, 5'd0, 1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        exp_v = exp_q.pop_front(); got = {ALU_input_rs, ALU_input_rt, Stall};
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL reset_empty: got rs=%b rt=%b stall=%b, want rs=%b rt=%b stall=%b",
                     got[8:5], got[4:1], got[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
        end
    endtask

    task automatic test_alu_forward();
        step_t steps [$];
        logic [8:0] exp_v;
        logic [8:0] got;
        do_reset();
        steps.push_back(mk(1'b1, 5'd1,  5'd2, 5'd5,  1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd5,  5'd2, 5'd6,  1'b1, 4'd1, 1'b0, 4'd1, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd6,  5'd5, 5'd0,  1'b0, 4'd1, 1'b0, 4'd1, 4'd2, 1'b0));
        steps.push_back(mk(1'b1, 5'd0,  5'd0, 5'd10, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd10, 5'd6, 5'd0,  1'b0, 4'd1, 1'b0, 4'd1, 4'd3, 1'b0));
        foreach (steps[i]) begin
            drive(steps[i]);
            exp_v = exp_q.pop_front(); got = {ALU_input_rs, ALU_input_rt, Stall};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL alu_forward step %0d: got rs=%b rt=%b stall=%b, want rs=%b rt=%b stall=%b",
                         i, got[8:5], got[4:1], got[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_mul_stall();
        step_t steps [$];
        logic [8:0] exp_v;
        logic [8:0] got;
        do_reset();
        steps.push_back(mk(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd7, 5'd3, 5'd8, 1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b1));
        steps.push_back(mk(1'b1, 5'd7, 5'd3, 5'd8, 1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b1));
        steps.push_back(mk(1'b1, 5'd7, 5'd3, 5'd8, 1'b1, 4'd1, 1'b0, 4'd3, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd8, 5'd7, 5'd9, 1'b1, 4'd1, 1'b0, 4'd1, 4'd4, 1'b0));
        foreach (steps[i]) begin
            drive(steps[i]);
            exp_v = exp_q.pop_front(); got = {ALU_input_rs, ALU_input_rt, Stall};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL mul_stall step %0d: got rs=%b rt=%b stall=%b, want rs=%b rt=%b stall=%b",
                         i, got[8:5], got[4:1], got[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_youngest_wins();
        step_t steps [$];
        logic [8:0] exp_v;
        logic [8:0] got;
        do_reset();
        steps.push_back(mk(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b0, 5'd9, 5'd9, 5'd0, 1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 4'd1, 1'b0, 4'd2, 4'd2, 1'b0));
        steps.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd9, 5'd1, 5'd0, 1'b0, 4'd1, 1'b0, 4'd5, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 4'd1, 1'b0, 4'd6, 4'd0, 1'b0));
        steps.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 4'd1, 1'b0, 4'd8, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        foreach (steps[i]) begin
            drive(steps[i]);
            exp_v = exp_q.pop_front(); got = {ALU_input_rs, ALU_input_rt, Stall};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL youngest_wins step %0d: got rs=%b rt=%b stall=%b, want rs=%b rt=%b stall=%b",
                         i, got[8:5], got[4:1], got[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_r0_write();
        step_t steps [$];
        logic [8:0] exp_v;
        logic [8:0] got;
        do_reset();
        steps.push_back(mk(1'b1, 5'd0,  5'd0, 5'd0,  1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd1,  5'd2, 5'd11, 1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd11, 5'd0, 5'd0,  1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        foreach (steps[i]) begin
            drive(steps[i]);
            exp_v = exp_q.pop_front(); got = {ALU_input_rs, ALU_input_rt, Stall};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL r0_write step %0d: got rs=%b rt=%b stall=%b, want rs=%b rt=%b stall=%b",
                         i, got[8:5], got[4:1], got[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
            end
            if (i == 1) begin
                n_cmp++;
                if (dut.slots_r[1].valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL r0_slot1_valid: got %b, want 0", dut.slots_r[1].valid);
                end
            end
        end
    endtask

    task automatic test_load_use();
        step_t steps [$];
        logic [8:0] exp_v;
        logic [8:0] got;
        do_reset();
        steps.push_back(mk(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 4'd7, 1'b0, 4'd0, 4'd0, 1'b0));
        for (int j = 0; j < 6; j++) begin
            steps.push_back(mk(1'b1, 5'd4, 5'd0, 5'd12, 1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b1));
        end
        steps.push_back(mk(1'b1, 5'd4, 5'd0, 5'd12, 1'b1, 4'd1, 1'b0, 4'd7, 4'd0, 1'b0));
        foreach (steps[i]) begin
            drive(steps[i]);
            exp_v = exp_q.pop_front(); got = {ALU_input_rs, ALU_input_rt, Stall};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL load_use step %0d: got rs=%b rt=%b stall=%b, want rs=%b rt=%b stall=%b",
                         i, got[8:5], got[4:1], got[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
            end
        end
        steps.delete();
        do_reset();
        steps.push_back(mk(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 4'd7, 1'b0, 4'd0, 4'd0, 1'b0));
        for (int j = 0; j < 7; j++) begin
            steps.push_back(mk(1'b1, 5'd1, 5'd2, 5'(20 + j), 1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        end
        steps.push_back(mk(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 4'd1, 1'b0, 4'd8, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd0, 5'd4, 5'd0, 1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0));
        foreach (steps[i]) begin
            drive(steps[i]);
            exp_v = exp_q.pop_front(); got = {ALU_input_rs, ALU_input_rt, Stall};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL load_drain step %0d: got rs=%b rt=%b stall=%b, want rs=%b rt=%b stall=%b",
                         i, got[8:5], got[4:1], got[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_flush_and_reset();
        step_t steps [$];
        logic [8:0] exp_v;
        logic [8:0] got;
        do_reset();
        steps.push_back(mk(1'b1, 5'd0,  5'd0, 5'd4,  1'b1, 4'd7, 1'b0, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd4,  5'd0, 5'd12, 1'b1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b1));
        steps.push_back(mk(1'b1, 5'd4,  5'd0, 5'd12, 1'b1, 4'd1, 1'b1, 4'd0, 4'd0, 1'b0));
        steps.push_back(mk(1'b1, 5'd12, 5'd4, 5'd0,  1'b0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b1));
        foreach (steps[i]) begin
            drive(steps[i]);
            exp_v = exp_q.pop_front(); got = {ALU_input_rs, ALU_input_rt, Stall};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL flush step %0d: got rs=%b rt=%b stall=%b, want rs=%b rt=%b stall=%b",
                         i, got[8:5], got[4:1], got[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
            end
        end
        #1;
        Rst_n = 1'b0;
        exp_q.push_back({4'd0, 4'd0, 1'b0});
        #1;
        exp_v = exp_q.pop_front(); got = {ALU_input_rs, ALU_input_rt, Stall};
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL async_reset_mid_stall: got rs=%b rt=%b stall=%b, want rs=%b rt=%b stall=%b",
                     got[8:5], got[4:1], got[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
        end
        #2;
        Rst_n = 1'b1;
        EX_Valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_mul_stall();
        test_youngest_wins();
        test_r0_write();
        test_load_use();
        test_flush_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
